// File: rtl/key_reader.sv
// Read-side companion to key_storage: snapshots the stored key on request and
// streams it MSB word first over valid/ready, with zeroize, sticky lock and abort on rewrite.
module key_reader #(
    parameter int unsigned KEY_WIDTH  = 128,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEY_WIDTH-1:0]  key_data_in,
    input  logic                  key_write,
    input  logic                  key_req,
    input  logic                  zeroize,
    input  logic                  read_lock,
    output logic [WORD_WIDTH-1:0] key_word,
    output logic                  key_word_valid,
    input  logic                  key_word_ready,
    output logic                  key_busy,
    output logic                  key_done,
    output logic                  key_err,
    output logic                  locked
);

    localparam int unsigned NUM_WORDS = KEY_WIDTH / WORD_WIDTH;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [KEY_WIDTH-1:0] snapshot_q, snapshot_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic [WORD_WIDTH-1:0] word_sel;
    logic                 handshake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            snapshot_q <= '0;
            index_q    <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            snapshot_q <= snapshot_d;
            index_q    <= index_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    assign handshake = (state_q == SEND) && key_word_ready;

    always_comb begin
        state_d    = state_q;
        snapshot_d = snapshot_q;
        index_d    = index_q;
        err_d      = 1'b0;
        locked_d   = locked_q | read_lock;

        case (state_q)
            IDLE: begin
                if (key_req) begin
                    if (locked_q) err_d   = 1'b1;
                    else          state_d = LOAD;
                end
            end
            LOAD: begin
                if (key_write) begin
                    state_d    = IDLE;
                    snapshot_d = '0;
                    index_d    = '0;
                    err_d      = 1'b1;
                end else begin
                    snapshot_d = key_data_in;
                    index_d    = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // A rewrite of the stored key invalidates the snapshot; the
                // handshake in the same cycle is discarded.
                if (key_write) begin
                    state_d    = IDLE;
                    snapshot_d = '0;
                    index_d    = '0;
                    err_d      = 1'b1;
                end else if (handshake) begin
                    if (index_q == LAST_IDX) state_d = DONE;
                    else                     index_d = index_q + 1'b1;
                end
            end
            DONE: begin
                snapshot_d = '0;
                index_d    = '0;
                state_d    = IDLE;
            end
            default: begin
                snapshot_d = '0;
                index_d    = '0;
                state_d    = IDLE;
            end
        endcase

        // Zeroize overrides every other transition, including a rejected request.
        if (zeroize) begin
            state_d    = IDLE;
            snapshot_d = '0;
            index_d    = '0;
            err_d      = 1'b0;
        end
    end

    always_comb begin
        word_sel = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (index_q == IDX_W'(i)) begin
                word_sel = snapshot_q[KEY_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH];
            end
        end
    end

    assign key_word_valid = (state_q == SEND);
    assign key_word       = key_word_valid ? word_sel : '0;
    assign key_busy       = (state_q == LOAD) || (state_q == SEND);
    assign key_done       = (state_q == DONE);
    assign key_err        = err_q;
    assign locked         = locked_q;

endmodule

// File: tb/tb_key_reader.sv
// Scoreboard bench for key_reader: stimulus pushes expected words/done/err events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_key_reader;

    localparam int unsigned KW = 128;
    localparam int unsigned WW = 32;

    logic          clk;
    logic          rst_n;
    logic [KW-1:0] key_data_in;
    logic          key_write;
    logic          key_req;
    logic          zeroize;
    logic          read_lock;
    logic [WW-1:0] key_word;
    logic          key_word_valid;
    logic          key_word_ready;
    logic          key_busy;
    logic          key_done;
    logic          key_err;
    logic          locked;

    key_reader #(.KEY_WIDTH(KW), .WORD_WIDTH(WW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_data_in    (key_data_in),
        .key_write      (key_write),
        .key_req        (key_req),
        .zeroize        (zeroize),
        .read_lock      (read_lock),
        .key_word       (key_word),
        .key_word_valid (key_word_valid),
        .key_word_ready (key_word_ready),
        .key_busy       (key_busy),
        .key_done       (key_done),
        .key_err        (key_err),
        .locked         (locked)
    );

    typedef enum int {EV_WORD, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        logic [WW-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  total_cnt = 0;
    int  pass_cnt  = 0;

    localparam logic [KW-1:0] KEY1 = 128'h00112233_445566778899AABB_CCDDEEFF;
    localparam logic [KW-1:0] KEY2 = 128'd15884;
    logic [WW-1:0] key1_words [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else             pass_cnt++;
    endtask

    task automatic push(input ev_kind_t k, input logic [WW-1:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_key1_all();
        for (int i = 0; i < 4; i++) push(EV_WORD, key1_words[i]);
        push(EV_DONE, '0);
    endtask

    task automatic expect_event(input ev_kind_t k, input logic [WW-1:0] d);
        ev_t e;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d data %0h expected no event", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data !== d)
                $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h", k, d, e.kind, e.data);
            else
                pass_cnt++;
        end
    endtask

    // Monitor
    logic          prev_hold = 1'b0;
    logic [WW-1:0] prev_word = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!key_word_valid) check("word_zero_when_invalid", KW'(key_word), '0);
            if (prev_hold) begin
                check("hold_valid", KW'(key_word_valid), KW'(1'b1));
                check("hold_word", KW'(key_word), KW'(prev_word));
            end
            if (key_word_valid && key_word_ready && !key_write && !zeroize) expect_event(EV_WORD, key_word);
            if (key_done) expect_event(EV_DONE, '0);
            if (key_err)  expect_event(EV_ERR, '0);
        end
        prev_hold = rst_n && key_word_valid && !key_word_ready && !key_write && !zeroize;
        prev_word = key_word;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s: timeout with %0d events pending, expected 0", name, exp_q.size());
        else                   pass_cnt++;
        tick();
    endtask

    task automatic req_pulse();
        key_req = 1'b1;
        tick();
        key_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    logic [1:0] rdy_pat = 2'b00;
    logic [3:0] pattern = 4'b1001;

    initial begin
        rst_n = 1'b0; key_data_in = '0; key_write = 1'b0; key_req = 1'b0;
        zeroize = 1'b0; read_lock = 1'b0; key_word_ready = 1'b0;
        #3;
        check("reset_valid", KW'(key_word_valid), '0);
        check("reset_busy",  KW'(key_busy), '0);
        check("reset_done",  KW'(key_done), '0);
        check("reset_err",   KW'(key_err), '0);
        check("reset_lock",  KW'(locked), '0);
        check("reset_word",  KW'(key_word), '0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic streaming with ready held high
        key_data_in = KEY1; key_word_ready = 1'b1;
        push_key1_all();
        req_pulse();
        check("load_busy",  KW'(key_busy), KW'(1'b1));
        check("load_valid", KW'(key_word_valid), '0);
        tick();
        check("send_valid", KW'(key_word_valid), KW'(1'b1));
        check("send_word0", KW'(key_word), KW'(32'h00112233));
        drain("basic_stream", 20);
        check("post_busy", KW'(key_busy), '0);
        check("post_word", KW'(key_word), '0);

        // Ready toggling 1,0,0,1 with back-pressure
        push_key1_all();
        key_word_ready = 1'b0;
        req_pulse();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            key_word_ready = pattern[i % 4];
            tick();
        end
        key_word_ready = 1'b0;
        drain("toggle_stream", 5);

        // Key change without key_write, then abort by key_write
        push(EV_WORD, 32'h00112233);
        push(EV_WORD, 32'h44556677);
        push(EV_ERR, '0);
        req_pulse();
        tick();
        key_data_in = KEY2;
        key_word_ready = 1'b1;
        tick();
        tick();
        key_word_ready = 1'b1;
        key_write = 1'b1;
        tick();
        key_write = 1'b0;
        key_word_ready = 1'b0;
        check("abort_valid", KW'(key_word_valid), '0);
        check("abort_busy",  KW'(key_busy), '0);
        drain("abort_stream", 5);
        repeat (3) tick();
        key_data_in = KEY1;

        // Zeroize at index 2 overrides a pending handshake
        push(EV_WORD, 32'h00112233);
        push(EV_WORD, 32'h44556677);
        key_word_ready = 1'b1;
        req_pulse();
        tick();
        tick();
        tick();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("zero_valid", KW'(key_word_valid), '0);
        check("zero_word",  KW'(key_word), '0);
        check("zero_busy",  KW'(key_busy), '0);
        check("zero_err",   KW'(key_err), '0);
        check("zero_done",  KW'(key_done), '0);
        drain("zeroize_partial", 3);
        push_key1_all();
        req_pulse();
        drain("after_zeroize", 20);

        // Zeroize together with a request in IDLE: no transfer
        key_req = 1'b1; zeroize = 1'b1;
        tick();
        key_req = 1'b0; zeroize = 1'b0;
        check("zero_req_busy", KW'(key_busy), '0);
        tick();

        // Lock rejects requests until reset
        read_lock = 1'b1;
        tick();
        read_lock = 1'b0;
        check("lock_set", KW'(locked), KW'(1'b1));
        push(EV_ERR, '0);
        req_pulse();
        check("lock_busy", KW'(key_busy), '0);
        tick();
        check("lock_valid", KW'(key_word_valid), '0);
        drain("lock_reject", 5);
        #2 rst_n = 1'b0;
        #2;
        check("lock_cleared", KW'(locked), '0);
        tick();
        rst_n = 1'b1;
        tick();
        push_key1_all();
        req_pulse();
        drain("after_unlock", 20);

        // Asynchronous reset mid-SEND
        key_word_ready = 1'b0;
        req_pulse();
        tick();
        check("pre_rst_valid", KW'(key_word_valid), KW'(1'b1));
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", KW'(key_word_valid), '0);
        check("async_word",  KW'(key_word), '0);
        check("async_busy",  KW'(key_busy), '0);
        check("async_done",  KW'(key_done), '0);
        check("async_err",   KW'(key_err), '0);
        check("async_lock",  KW'(locked), '0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL final_queue: got %0d pending, expected 0", exp_q.size());
        else                   pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
